// File: rtl/uart_frame_sched_if.sv
// uart_frame_sched_if: sample input, uart_tx byte handshake and status
// signals of the AD7606-to-UART frame sequencer.
interface uart_frame_sched_if #(
  parameter int unsigned NUM_CH = 8
);
  logic                  smp_valid;
  logic [16*NUM_CH-1:0]  smp_data;
  logic                  frame_ready;
  logic                  uart_tx_we;
  logic [7:0]            data_tx;
  logic                  uart_tx_end;
  logic                  frame_done;
  logic [7:0]            drop_cnt;

  // Sequencer side: consumes samples and uart_tx_end, drives uart_tx.
  modport slave (
    input  smp_valid, smp_data, uart_tx_end,
    output frame_ready, uart_tx_we, data_tx, frame_done, drop_cnt
  );

  // Environment side: capture logic plus uart_tx.
  modport master (
    output smp_valid, smp_data, uart_tx_end,
    input  frame_ready, uart_tx_we, data_tx, frame_done, drop_cnt
  );
endinterface

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: packs one AD7606 conversion set into a UART frame
// (HDR0, HDR1, ch0 hi/lo .. chN-1 hi/lo [, checksum]) and hands it to
// uart_tx one byte per uart_tx_end. Strobes arriving mid-frame are dropped
// and counted. Define UART_FRAME_CKSUM_EN to append the 8-bit data checksum.
module uart_frame_sched #(
  parameter int unsigned NUM_CH = 8,
  parameter logic [7:0]  HDR0   = 8'hAA,
  parameter logic [7:0]  HDR1   = 8'h55
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_sched_if.slave   bus
);

  localparam int unsigned DATA_BYTES = 2 * NUM_CH;
`ifdef UART_FRAME_CKSUM_EN
  localparam int unsigned FRAME_LEN  = 3 + DATA_BYTES;
`else
  localparam int unsigned FRAME_LEN  = 2 + DATA_BYTES;
`endif
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned SMP_W      = 16 * NUM_CH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LO  = IDX_W'(2);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e             state_q, state_d;
  logic [SMP_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         data_tx_q, data_tx_d;
  logic               we_q, we_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [7:0]         drop_q, drop_d;
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0]         cksum_q, cksum_d;
`endif

  logic [IDX_W-1:0]   idx_nxt;
  logic [7:0]         nxt_byte;
  logic               last_end;
  logic               accept;
  logic               drop;

  // Channel byte for frame index i (i >= 2): even offsets are the high byte.
  function automatic logic [7:0] pick_byte(input logic [SMP_W-1:0] smp,
                                           input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] off;
    logic [7:0]       b;
    off = i - DATA_LO;
    b   = 8'h00;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(off[IDX_W-1:1]) == c) begin
        b = off[0] ? smp[16*c +: 8] : smp[16*c+8 +: 8];
      end
    end
    return b;
  endfunction

  // Next-state and next-output logic; acceptance overrides the frame tail.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    data_tx_d = data_tx_q;
    we_d      = we_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    drop_d    = drop_q;
`ifdef UART_FRAME_CKSUM_EN
    cksum_d   = cksum_q;
`endif

    idx_nxt  = idx_q + IDX_W'(1);
    nxt_byte = pick_byte(shadow_q, idx_nxt);
    last_end = (state_q == SEND) && bus.uart_tx_end && (idx_q == LAST_IDX);
    accept   = bus.smp_valid && ((state_q == IDLE) || last_end);
    drop     = bus.smp_valid && (state_q == SEND) && !last_end;

    case (state_q)
      IDLE: begin
        we_d    = 1'b0;
        ready_d = 1'b1;
      end
      SEND: begin
        if (bus.uart_tx_end) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_nxt;
            if (idx_nxt == IDX_W'(1)) begin
              data_tx_d = HDR1;
            end
`ifdef UART_FRAME_CKSUM_EN
            else if (idx_nxt == LAST_IDX) begin
              data_tx_d = cksum_q;
            end else begin
              data_tx_d = nxt_byte;
              cksum_d   = cksum_q + nxt_byte;
            end
`else
            else begin
              data_tx_d = nxt_byte;
            end
`endif
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            we_d    = 1'b0;
            ready_d = 1'b1;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d   = SEND;
      shadow_d  = bus.smp_data;
      idx_d     = '0;
      data_tx_d = HDR0;
      we_d      = 1'b1;
      ready_d   = 1'b0;
`ifdef UART_FRAME_CKSUM_EN
      cksum_d   = 8'h00;
`endif
    end

    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      data_tx_q <= 8'h00;
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      drop_q    <= 8'h00;
`ifdef UART_FRAME_CKSUM_EN
      cksum_q   <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      data_tx_q <= data_tx_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
`ifdef UART_FRAME_CKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  assign bus.uart_tx_we  = we_q;
  assign bus.data_tx     = data_tx_q;
  assign bus.frame_ready = ready_q;
  assign bus.frame_done  = done_q;
  assign bus.drop_cnt    = drop_q;

endmodule
